// File: rtl/ysyx_22040237_ifu_if.sv
// IFU-side bundle: redirect input, instruction-memory request/response, IDU hand-off.
// master = IFU, slave = environment (EXU redirect path, memory, IDU).
interface ysyx_22040237_ifu_if #(
  parameter int unsigned XLEN = 64
);
  logic            redirect_valid_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            imem_req_valid_o;
  logic            imem_req_ready_i;
  logic [XLEN-1:0] imem_req_addr_o;
  logic            imem_rsp_valid_i;
  logic [31:0]     imem_rsp_data_i;
  logic            inst_valid_o;
  logic            inst_ready_i;
  logic [31:0]     inst_o;
  logic [XLEN-1:0] pc_o;

  modport master (
    input  redirect_valid_i, redirect_pc_i, imem_req_ready_i, imem_rsp_valid_i,
           imem_rsp_data_i, inst_ready_i,
    output imem_req_valid_o, imem_req_addr_o, inst_valid_o, inst_o, pc_o
  );

  modport slave (
    output redirect_valid_i, redirect_pc_i, imem_req_ready_i, imem_rsp_valid_i,
           imem_rsp_data_i, inst_ready_i,
    input  imem_req_valid_o, imem_req_addr_o, inst_valid_o, inst_o, pc_o
  );
endinterface

// File: rtl/ysyx_22040237_ifu.sv
// Instruction fetch unit: owns the PC, one outstanding imem read, buffers the word for the IDU.
// Optional YSYX_22040237_IFU_PERF_EN adds fetch/stall performance counters.
module ysyx_22040237_ifu #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h0000_0000_8000_0000)
) (
  input  logic                clk,
  input  logic                rst_n,
  ysyx_22040237_ifu_if.master bus
`ifdef YSYX_22040237_IFU_PERF_EN
  ,
  output logic [63:0]         perf_fetch_cnt_o,
  output logic [63:0]         perf_stall_cnt_o
`endif
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e          r_state, w_state_d;
  logic [XLEN-1:0] r_pc, w_pc_d;
  logic            r_kill, w_kill_d;
  logic [31:0]     r_inst, w_inst_d;

  logic [XLEN-1:0] w_redirect_pc;
  logic            w_req_fire;

  assign w_redirect_pc = bus.redirect_pc_i & ~XLEN'(3);
  assign w_req_fire    = (r_state == StReq) && bus.imem_req_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_pc    <= RESET_PC;
      r_kill  <= 1'b0;
      r_inst  <= '0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      r_kill  <= w_kill_d;
      r_inst  <= w_inst_d;
    end
  end

  always_comb begin
    w_state_d            = r_state;
    w_pc_d               = r_pc;
    w_kill_d             = r_kill;
    w_inst_d             = r_inst;
    bus.imem_req_valid_o = 1'b0;
    bus.imem_req_addr_o  = '0;
    bus.inst_valid_o     = 1'b0;
    bus.inst_o           = '0;
    bus.pc_o             = '0;

    // Redirect retargets the PC in every active state; IDLE ignores it.
    if (r_state != StIdle && bus.redirect_valid_i) begin
      w_pc_d = w_redirect_pc;
    end

    unique case (r_state)
      StIdle: w_state_d = StReq;
      StReq: begin
        bus.imem_req_valid_o = 1'b1;
        bus.imem_req_addr_o  = r_pc;
        if (w_req_fire) begin
          w_state_d = StWait;
          // Accepted request targets the old PC, so its response must be dropped.
          if (bus.redirect_valid_i) w_kill_d = 1'b1;
        end
      end
      StWait: begin
        if (bus.imem_rsp_valid_i) begin
          if (r_kill || bus.redirect_valid_i) begin
            w_kill_d  = 1'b0;
            w_state_d = StReq;
          end else begin
            w_inst_d  = bus.imem_rsp_data_i;
            w_state_d = StHold;
          end
        end else if (bus.redirect_valid_i) begin
          w_kill_d = 1'b1;
        end
      end
      StHold: begin
        bus.inst_valid_o = ~bus.redirect_valid_i;
        bus.inst_o       = r_inst;
        bus.pc_o         = r_pc;
        if (bus.redirect_valid_i) begin
          w_state_d = StReq;
        end else if (bus.inst_ready_i) begin
          w_pc_d    = r_pc + XLEN'(4);
          w_state_d = StReq;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

`ifdef YSYX_22040237_IFU_PERF_EN
  logic w_fetch_inc;
  logic w_stall_inc;

  assign w_fetch_inc = bus.inst_valid_o && bus.inst_ready_i;
  assign w_stall_inc = ((r_state == StReq) && !bus.imem_req_ready_i) || (r_state == StWait);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt_o <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      if (w_fetch_inc) perf_fetch_cnt_o <= perf_fetch_cnt_o + 64'd1;
      if (w_stall_inc) perf_stall_cnt_o <= perf_stall_cnt_o + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22040237_ifu.sv
// Self-checking bench for ysyx_22040237_ifu: PC-stream model plus directed redirect/stall scenarios.
// Perf counter checks are built only with YSYX_22040237_IFU_PERF_EN defined.
module tb_ysyx_22040237_ifu;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ysyx_22040237_ifu_if #(.XLEN(64)) bus ();

`ifdef YSYX_22040237_IFU_PERF_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_stall_cnt;
`endif

  ysyx_22040237_ifu #(
    .XLEN     (64),
    .RESET_PC (RESET_PC)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef YSYX_22040237_IFU_PERF_EN
    ,
    .perf_fetch_cnt_o (perf_fetch_cnt),
    .perf_stall_cnt_o (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int lat    = 1;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_0000) return 32'h0010_0513;
    return {a[15:0], a[31:16]} ^ 32'hdead_beef;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory: one response lat cycles after acceptance; forgotten on reset.
  logic        mem_pend;
  int          mem_cnt;
  logic [63:0] mem_addr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_pend <= 1'b0;
      mem_cnt  <= 0;
      mem_addr <= '0;
    end else if (mem_pend) begin
      if (mem_cnt == 0) mem_pend <= 1'b0;
      else mem_cnt <= mem_cnt - 1;
    end else if (bus.imem_req_valid_o && bus.imem_req_ready_i) begin
      mem_pend <= 1'b1;
      mem_cnt  <= lat - 1;
      mem_addr <= bus.imem_req_addr_o;
    end
  end

  assign bus.imem_rsp_valid_i = mem_pend && (mem_cnt == 0);
  assign bus.imem_rsp_data_i  = mem_pend ? mem_word(mem_addr) : 32'h0;

  // Transaction model: the PC stream the IDU must see, given handshakes and redirects.
  logic [63:0] m_pc;
  logic        m_out;
  logic        m_prev_stall;

  always @(negedge clk) begin
    logic [63:0] nxt;
    if (!rst_n) begin
      m_pc         <= RESET_PC;
      m_out        <= 1'b0;
      m_prev_stall <= 1'b0;
    end else begin
      nxt = m_pc;
      if (bus.imem_req_valid_o && bus.imem_req_ready_i) begin
        chk("req_addr", bus.imem_req_addr_o, m_pc);
        chk("one_outstanding", {63'd0, m_out}, 64'd0);
      end
      if (bus.redirect_valid_i) chk("no_valid_on_redirect", {63'd0, bus.inst_valid_o}, 64'd0);
      else if (m_prev_stall) chk("hold_stable", {63'd0, bus.inst_valid_o}, 64'd1);
      if (bus.inst_valid_o) begin
        chk("pc_o", bus.pc_o, m_pc);
        chk("inst_o", {32'd0, bus.inst_o}, {32'd0, mem_word(m_pc)});
      end
      if (bus.inst_valid_o && bus.inst_ready_i) nxt = m_pc + 64'd4;
      if (bus.redirect_valid_i) nxt = {bus.redirect_pc_i[63:2], 2'b00};
      m_pc <= nxt;
      if (bus.imem_req_valid_o && bus.imem_req_ready_i) m_out <= 1'b1;
      else if (bus.imem_rsp_valid_i) m_out <= 1'b0;
      m_prev_stall <= bus.inst_valid_o && !bus.inst_ready_i;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm);
    int k = 0;
    while (!bus.inst_valid_o && k < 40) begin
      tick();
      k++;
    end
    if (!bus.inst_valid_o) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: inst_valid_o got 0 expected 1 within 40 cycles", nm);
    end
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_req_valid"}, {63'd0, bus.imem_req_valid_o}, 64'd0);
    chk({nm, "_req_addr"}, bus.imem_req_addr_o, 64'd0);
    chk({nm, "_inst_valid"}, {63'd0, bus.inst_valid_o}, 64'd0);
    chk({nm, "_inst"}, {32'd0, bus.inst_o}, 64'd0);
    chk({nm, "_pc"}, bus.pc_o, 64'd0);
  endtask

  initial begin
    int stale;
    int hs;
    int k;
    bus.redirect_valid_i = 1'b0;
    bus.redirect_pc_i    = '0;
    bus.imem_req_ready_i = 1'b1;
    bus.inst_ready_i     = 1'b1;
    repeat (2) tick();
    chk_outputs_zero("reset");

    // First fetch with a single-cycle memory and ready IDU.
    rst_n = 1'b1;
    tick();
    chk("first_req_valid", {63'd0, bus.imem_req_valid_o}, 64'd1);
    chk("first_req_addr", bus.imem_req_addr_o, 64'h8000_0000);
    tick();
    tick();
    chk("first_inst_valid", {63'd0, bus.inst_valid_o}, 64'd1);
    chk("first_inst", {32'd0, bus.inst_o}, 64'h0010_0513);
    chk("first_pc", bus.pc_o, 64'h8000_0000);
    tick();
    chk("second_req_addr", bus.imem_req_addr_o, 64'h8000_0004);

    // IDU back-pressure for 5 cycles in HOLD.
    bus.inst_ready_i = 1'b0;
    wait_valid("stall_wait");
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {63'd0, bus.inst_valid_o}, 64'd1);
      chk("stall_pc", bus.pc_o, 64'h8000_0004);
      chk("stall_no_req", {63'd0, bus.imem_req_valid_o}, 64'd0);
      tick();
    end
    bus.inst_ready_i = 1'b1;
    tick();
    chk("after_stall_addr", bus.imem_req_addr_o, 64'h8000_0008);

    // Redirect in WAIT with 3-cycle memory: stale word dropped.
    lat = 3;
    tick();
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 64'h8000_0101;
    tick();
    bus.redirect_valid_i = 1'b0;
    stale = 0;
    k = 0;
    while (!bus.imem_req_valid_o && k < 20) begin
      if (bus.inst_valid_o) stale++;
      tick();
      k++;
    end
    chk("stale_dropped", 64'(stale), 64'd0);
    chk("redir_wait_addr", bus.imem_req_addr_o, 64'h8000_0100);

    // Redirect in the same cycle as the response.
    lat = 1;
    tick();
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 64'h8000_0200;
    tick();
    bus.redirect_valid_i = 1'b0;
    chk("redir_rsp_req_valid", {63'd0, bus.imem_req_valid_o}, 64'd1);
    chk("redir_rsp_addr", bus.imem_req_addr_o, 64'h8000_0200);
    wait_valid("redir_rsp_wait");
    chk("redir_rsp_pc", bus.pc_o, 64'h8000_0200);
    chk("redir_rsp_inst", {32'd0, bus.inst_o}, {32'd0, mem_word(64'h8000_0200)});

    // Redirect in HOLD with ready high: no handshake.
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 64'h8000_0300;
    #1;
    chk("hold_redir_valid", {63'd0, bus.inst_valid_o}, 64'd0);
    tick();
    bus.redirect_valid_i = 1'b0;
    chk("hold_redir_addr", bus.imem_req_addr_o, 64'h8000_0300);

    // Redirect while the request is accepted, to the top of the address space.
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    bus.redirect_valid_i = 1'b0;
    tick();
    chk("wrap_req_addr", bus.imem_req_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
    wait_valid("wrap_wait");
    chk("wrap_pc", bus.pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("wrap_next_valid", {63'd0, bus.imem_req_valid_o}, 64'd1);
    chk("wrap_next_addr", bus.imem_req_addr_o, 64'd0);

    // Redirect while the request is not accepted.
    bus.imem_req_ready_i = 1'b0;
    tick();
    chk("unacc_addr_held", bus.imem_req_addr_o, 64'd0);
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 64'h8000_0402;
    tick();
    bus.redirect_valid_i = 1'b0;
    chk("unacc_req_valid", {63'd0, bus.imem_req_valid_o}, 64'd1);
    chk("unacc_redir_addr", bus.imem_req_addr_o, 64'h8000_0400);
    bus.imem_req_ready_i = 1'b1;
    wait_valid("unacc_wait");
    chk("unacc_pc", bus.pc_o, 64'h8000_0400);

    // Mid-operation reset while a request is outstanding.
    tick();
    lat = 3;
    tick();
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    lat = 2;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_addr", bus.imem_req_addr_o, 64'h8000_0000);

    // Ten instructions with a 2-cycle memory.
    hs = 0;
    k  = 0;
    while (hs < 10 && k < 200) begin
      if (bus.inst_valid_o && bus.inst_ready_i) hs++;
      tick();
      k++;
    end
    chk("ten_fetched", 64'(hs), 64'd10);
`ifdef YSYX_22040237_IFU_PERF_EN
    chk("perf_fetch", perf_fetch_cnt, 64'd10);
    chk("perf_stall", perf_stall_cnt, 64'd20);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ysyx_22040237_ifu.md
Name: ysyx_22040237_ifu

Overview:
Instruction fetch unit for the single-cycle/early-pipeline NPC core. It produces the inst/pc pair consumed by the IDU.
- Owns the PC register.
- Issues one instruction-memory read at a time over a valid/ready request + valid response interface.
- Buffers the returned word and presents it to the IDU with a valid/ready handshake.
- Accepts redirects from the EXU branch/jump path and kills stale fetches.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.
XLEN, 64, PC/address width.

Ports:
clk  input  1  clock, all state updates on posedge.
rst_n  input  1  reset, asynchronous, active-low.
redirect_valid_i  input  1  EXU branch/jump taken this cycle.
redirect_pc_i  input  XLEN  redirect target.
imem_req_valid_o  output  1  fetch request valid.
imem_req_ready_i  input  1  memory accepts request.
imem_req_addr_o  output  XLEN  fetch address.
imem_rsp_valid_i  input  1  read data valid (exactly one per accepted request, ≥1 cycle later).
imem_rsp_data_i  input  32  instruction word.
inst_valid_o  output  1  inst_o/pc_o valid to IDU.
inst_ready_i  input  1  IDU consumes instruction.
inst_o  output  32  instruction to IDU.
pc_o  output  XLEN  PC of inst_o.

Behaviour:
Reset (rst_n low, asynchronous):
- state=S_IDLE, pc_q=RESET_PC, kill_q=0, inst_q=0.
- All outputs 0.

FSM:
- S_IDLE: outputs 0; next clock -> S_REQ.
- S_REQ:
  - imem_req_valid_o=1, imem_req_addr_o=pc_q.
  - req_valid&&req_ready -> S_WAIT.
  - The address may change while unaccepted (redirect only).
- S_WAIT: on imem_rsp_valid_i:
  - kill_q=1 or redirect_valid_i=1: drop the word, kill_q<=0, -> S_REQ.
  - Otherwise: inst_q<=imem_rsp_data_i, -> S_HOLD.
  - A response in any other state is ignored (protocol violation; assertion in bench).
- S_HOLD:
  - inst_valid_o=~redirect_valid_i, inst_o=inst_q, pc_o=pc_q.
  - On inst_valid_o&&inst_ready_i: pc_q<=pc_q+4, -> S_REQ.
  - Data is held stable while ready is low.

Redirect (highest priority, any state except S_IDLE):
- pc_q<={redirect_pc_i[XLEN-1:2],2'b00}; low two bits are discarded.
- S_REQ, not accepted this cycle: stay in S_REQ; the new address is presented next cycle.
- S_REQ, accepted this cycle: the in-flight request is for the old PC -> S_WAIT with kill_q<=1.
- S_WAIT, no response this cycle: kill_q<=1, stay in S_WAIT.
- S_WAIT, response this cycle: drop the word, -> S_REQ.
- S_HOLD: held instruction discarded (inst_valid_o forced 0 that cycle), -> S_REQ.
- A redirect in S_IDLE is ignored.

Arithmetic:
- pc_q+4 is modulo 2^XLEN: 0xFFFF_FFFF_FFFF_FFFC -> 0.

Timing:
- At most one outstanding request.
- Minimum latency from request acceptance to inst_valid_o is 2 cycles: response ≥1 cycle after acceptance, then capture.
- Throughput is 1 instruction per 3 cycles with a single-cycle memory and ready IDU.

Mid-operation reset:
- Asynchronously returns to S_IDLE; any outstanding memory response is forgotten.
- The memory model must be reset together with the IFU.

Optional Feature:
YSYX_22040237_IFU_PERF_EN
- Defined: adds outputs perf_fetch_cnt_o[63:0] and perf_stall_cnt_o[63:0], both reset 0.
  - fetch_cnt increments on each inst_valid_o&&inst_ready_i.
  - stall_cnt increments each cycle in S_REQ with !imem_req_ready_i, or in S_WAIT.
  - Both wrap modulo 2^64.
- Undefined: ports and counters are absent; other behaviour is identical.

Test Plan:
- Reset release, single-cycle memory returning 0x00100513, IDU ready=1 -> first req addr 0x8000_0000; inst_o=0x00100513, pc_o=0x8000_0000; next req addr 0x8000_0004.
- IDU ready=0 for 5 cycles in S_HOLD -> inst_valid_o stays 1 with inst_o/pc_o unchanged; no new request; pc advances only after ready.
- Redirect to 0x8000_0101 in S_WAIT with 3-cycle memory latency -> stale word dropped, never valid to IDU; next req addr 0x8000_0100.
- Redirect to 0x8000_0200 in the same cycle as the response arrives -> word dropped, next req addr 0x8000_0200, kill_q ends 0.
- Redirect in S_HOLD with ready=1 the same cycle -> inst_valid_o=0 that cycle; no handshake; next req addr = redirect target.
- pc_q=0xFFFF_FFFF_FFFF_FFFC consumed -> next req addr 0. With YSYX_22040237_IFU_PERF_EN: 10 instructions fetched with 2-cycle memory -> perf_fetch_cnt_o=10, perf_stall_cnt_o=20.
